// File: rtl/stream_pkg.sv
// Shared types for the 1-to-2 stream demux: packet-lock FSM states and channel indices.
// Channel indices are single-bit because the destination select is a single wire.
package stream_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_t;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage : stream_pkg

// File: rtl/stream_demux_1to2_if.sv
// Boundary bundle of the demux: one upstream stream plus select, two downstream streams.
// The slave modport is the demux's view; master is the environment's view.
interface stream_demux_1to2_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic             sel;

   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_last;
   logic             out0_ready;

   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_last;
   logic             out1_ready;

   modport master (
      output in_data,
      output in_valid,
      output in_last,
      output sel,
      output out0_ready,
      output out1_ready,
      input  in_ready,
      input  out0_data,
      input  out0_valid,
      input  out0_last,
      input  out1_data,
      input  out1_valid,
      input  out1_last
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  in_last,
      input  sel,
      input  out0_ready,
      input  out1_ready,
      output in_ready,
      output out0_data,
      output out0_valid,
      output out0_last,
      output out1_data,
      output out1_valid,
      output out1_last
   );

endinterface : stream_demux_1to2_if

// File: rtl/stream_reg_slice.sv
// One-entry output register stage (valid/data/last) with 1-cycle latency.
// Accepts a new beat when empty or when the current one drains in the same cycle.
module stream_reg_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             can_load_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             last_q,  last_d;

   assign can_load_o = !valid_q || ready_i;

   // Data/last only change on a load, and a load only happens when the held beat
   // is leaving, so the outputs stay stable while the consumer stalls.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule : stream_reg_slice

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demux with a registered stage per output; beats appear 1 cycle after acceptance.
// STREAM_DEMUX_PKT_LOCK_EN: lock the destination for a whole packet (sel sampled on its first beat).
module stream_demux_1to2 #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   stream_demux_1to2_if.slave  bus
);

   import stream_pkg::*;

   logic dest;
   logic accept;
   logic can_load0;
   logic can_load1;
   logic load0;
   logic load1;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
   state_t state_q, state_d;
   logic   sel_q,   sel_d;

   assign dest = (state_q == S_PKT) ? sel_q : bus.sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= CH0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE: begin
            // A single-beat packet never leaves idle, so sel stays live for the next one.
            if (accept && !bus.in_last) begin
               state_d = S_PKT;
               sel_d   = bus.sel;
            end
         end
         S_PKT: begin
            if (accept && bus.in_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
`else
   assign dest = bus.sel;
`endif

   // Only the destination stage gates upstream; the other channel may stall freely.
   assign bus.in_ready = (dest == CH1) ? can_load1 : can_load0;
   assign accept       = bus.in_valid && bus.in_ready;
   assign load0        = accept && (dest == CH0);
   assign load1        = accept && (dest == CH1);

   stream_reg_slice #(
      .WIDTH (WIDTH)
   ) u_slice0 (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load0),
      .data_i     (bus.in_data),
      .last_i     (bus.in_last),
      .ready_i    (bus.out0_ready),
      .can_load_o (can_load0),
      .valid_o    (bus.out0_valid),
      .data_o     (bus.out0_data),
      .last_o     (bus.out0_last)
   );

   stream_reg_slice #(
      .WIDTH (WIDTH)
   ) u_slice1 (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load1),
      .data_i     (bus.in_data),
      .last_i     (bus.in_last),
      .ready_i    (bus.out1_ready),
      .can_load_o (can_load1),
      .valid_o    (bus.out1_valid),
      .data_o     (bus.out1_data),
      .last_o     (bus.out1_last)
   );

endmodule : stream_demux_1to2

// File: tb/tb_stream_demux_1to2.sv
// Randomized + directed bench for stream_demux_1to2 with a queue-based scoreboard.
// The reference model follows STREAM_DEMUX_PKT_LOCK_EN the same way as the design build.
module tb_stream_demux_1to2;

   localparam int W = 8;

   logic clk;
   logic rst;

   stream_demux_1to2_if #(.WIDTH(W)) bus ();

   stream_demux_1to2 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Each entry is {last, data}; a queue holds beats accepted for that channel but not yet consumed.
   logic [W:0] exp0[$];
   logic [W:0] exp1[$];

`ifdef STREAM_DEMUX_PKT_LOCK_EN
   bit   m_in_pkt   = 1'b0;
   logic m_lock_sel = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic mon_ch(input int ch, input logic v, input logic [W-1:0] d,
                         input logic l, input logic r);
      int         n;
      logic [W:0] head;
      n = (ch == 0) ? exp0.size() : exp1.size();
      check((ch == 0) ? "out0_valid" : "out1_valid", {31'd0, v}, {31'd0, n != 0});
      if (v && n != 0) begin
         head = (ch == 0) ? exp0[0] : exp1[0];
         check((ch == 0) ? "out0_beat" : "out1_beat", {23'd0, l, d}, {23'd0, head});
         if (r) begin
            if (ch == 0) void'(exp0.pop_front());
            else         void'(exp1.pop_front());
         end
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard every cycle.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_out0", {22'd0, bus.out0_valid, bus.out0_last, bus.out0_data}, 32'd0);
         check("rst_out1", {22'd0, bus.out1_valid, bus.out1_last, bus.out1_data}, 32'd0);
      end else begin
         mon_ch(0, bus.out0_valid, bus.out0_data, bus.out0_last, bus.out0_ready);
         mon_ch(1, bus.out1_valid, bus.out1_data, bus.out1_last, bus.out1_ready);
      end
   end

   // Drives one cycle starting just after a rising edge; returns whether the beat was taken.
   task automatic cycle_drive(input logic v, input logic [W-1:0] d, input logic l,
                              input logic s, input logic r0, input logic r1, output logic acc);
      logic mdest;
      logic exp_rdy;
      bus.in_valid   = v;
      bus.in_data    = d;
      bus.in_last    = l;
      bus.sel        = s;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      @(negedge clk);
      #1;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
      mdest = m_in_pkt ? m_lock_sel : s;
`else
      mdest = s;
`endif
      exp_rdy = mdest ? (exp1.size() == 0 || r1) : (exp0.size() == 0 || r0);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      acc = v && bus.in_ready;
      if (acc) begin
         if (mdest) exp1.push_back({l, d});
         else       exp0.push_back({l, d});
`ifdef STREAM_DEMUX_PKT_LOCK_EN
         if (!m_in_pkt && !l) begin
            m_in_pkt   = 1'b1;
            m_lock_sel = s;
         end else if (m_in_pkt && l) begin
            m_in_pkt = 1'b0;
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic s, input logic l,
                       input logic r0, input logic r1);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) cycle_drive(1'b1, d, l, s, r0, r1, acc);
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: beat %0h not accepted within 64 cycles", d);
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle_drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
   endtask

   task automatic pulse_reset();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_async_v0", {31'd0, bus.out0_valid}, 32'd0);
      check("rst_async_v1", {31'd0, bus.out1_valid}, 32'd0);
      exp0.delete();
      exp1.delete();
`ifdef STREAM_DEMUX_PKT_LOCK_EN
      m_in_pkt = 1'b0;
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic acc;
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_last    = 1'b0;
      bus.sel        = 1'b0;
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single beat to channel 0
      send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);

      // Alternating destinations, both consumers ready
      for (int i = 1; i <= 4; i++) send(W'(i), i[0] ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);

      // Channel 0 stalled: second sel=0 beat blocked, sel=1 beat still flows
      send(8'h10, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle_drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, acc);
      check("stalled_beat_acc", {31'd0, acc}, 32'd0);
      send(8'h20, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
      send(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);

      // Three-beat packet with sel changing after the first beat, then a new packet
      send(8'h31, 1'b1, 1'b0, 1'b1, 1'b1);
      send(8'h32, 1'b0, 1'b0, 1'b1, 1'b1);
      send(8'h33, 1'b0, 1'b1, 1'b1, 1'b1);
      send(8'h34, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);

      // Reset mid-packet with beats buffered on both channels
      send(8'h50, 1'b0, 1'b1, 1'b0, 1'b0);
      send(8'h51, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_reset();
      send(8'h52, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);

      // Sustained stream to channel 1
      for (int i = 0; i < 16; i++) begin
         cycle_drive(1'b1, W'(8'h40 + i), (i == 15), 1'b1, 1'b1, 1'b1, acc);
         check("stream_acc", {31'd0, acc}, 32'd1);
      end
      idle(2);

      // Random traffic with random back-pressure
      for (int i = 0; i < 600; i++) begin
         cycle_drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0,
                     1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
      end

      idle(4);
      check("drain_q0", exp0.size(), 32'd0);
      check("drain_q1", exp1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_stream_demux_1to2

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter WIDTH, default 8, sets the payload bit width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  WIDTH  upstream payload.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_last  input  1  marks the final beat of a packet.
REQ-007 in_ready  output  1  block accepts the current beat.
REQ-008 sel  input  1  destination select: 0 routes to out0, 1 routes to out1.
REQ-009 out0_data / out0_valid / out0_last  output  WIDTH/1/1  channel 0 payload, valid and last.
REQ-010 out0_ready  input  1  channel 0 consumer accepts.
REQ-011 out1_data / out1_valid / out1_last  output  WIDTH/1/1  channel 1 payload, valid and last.
REQ-012 out1_ready  input  1  channel 1 consumer accepts.

Function
REQ-013 A transfer occurs on any port when its valid and ready are both 1 at a rising clk edge.
REQ-014 Each output channel holds a one-entry register stage (valid, data, last); input-to-output latency is exactly 1 cycle.
REQ-015 The effective destination dest is sel in S_IDLE and sel_q in S_PKT.
REQ-016 in_ready is combinational: 1 when the dest stage is empty or its consumer is ready in the same cycle; the other channel has no effect on it.
REQ-017 An accepted beat loads in_data/in_last into the dest stage only; the non-dest stage is unchanged.
REQ-018 Once set, outN_valid stays 1 and outN_data/outN_last stay stable until outN_ready is 1.
REQ-019 A simultaneous drain and load of the same stage leaves outN_valid at 1 holding the new beat, with no bubble.
REQ-020 A stage that is drained and not reloaded clears outN_valid the next cycle.
REQ-021 Back-pressure on one channel never stalls draining of the other channel's already-registered beat.
REQ-022 Sustained throughput to one channel is 1 beat/cycle while its consumer holds ready at 1.

Reset
REQ-023 While rst=1: out0_valid=out1_valid=0, out0_data=out1_data=0, out0_last=out1_last=0, sel_q=0, FSM in S_IDLE.
REQ-024 rst asserted mid-packet discards all buffered beats and packet lock immediately; the first beat after release is routed per REQ-015 from S_IDLE.

Configuration
REQ-025 Macro STREAM_DEMUX_PKT_LOCK_EN controls the packet lock.
REQ-026 With STREAM_DEMUX_PKT_LOCK_EN defined: FSM states are S_IDLE and S_PKT. Accepting a beat with in_last=0 in S_IDLE captures sel into sel_q and enters S_PKT. Accepting a beat with in_last=1 returns to S_IDLE. Changes on sel in S_PKT are ignored. A single-beat packet (in_last=1 on the first beat) stays in S_IDLE.
REQ-027 Without STREAM_DEMUX_PKT_LOCK_EN: no FSM and no sel_q; dest=sel on every beat. in_last passes through as data only.

Structure
REQ-028 The shared package stream_pkg holds the FSM state typedef (S_IDLE, S_PKT) and the channel index constants CH0=0 and CH1=1.
REQ-029 The per-channel register stage is the sub-module stream_reg_slice, parameterised by WIDTH and instantiated twice.

Verification
REQ-030 Reset release, sel=0, one beat 0xA5 with last=1 and out0_ready=1 -> out0_valid=1 with 0xA5 on the next cycle; out1_valid stays 0.
REQ-031 Beats 0x01..0x04 alternating sel=0,1,0,1, both readys 1 -> out0 receives 0x01 then 0x03, out1 receives 0x02 then 0x04, each 1 cycle after acceptance.
REQ-032 out0_ready=0, two beats with sel=0 -> the first is held on out0, in_ready=0 for the second; a sel=1 beat is still accepted and appears on out1.
REQ-033 With PKT_LOCK_EN: 3-beat packet, sel=1 on beat 1, sel=0 on beats 2-3 -> all three beats appear on out1, and the next packet follows sel.
REQ-034 rst pulsed while out0_valid=1 in S_PKT -> out0_valid=0 immediately; after release a beat with sel=0 goes to out0.
REQ-035 out1_ready=1, continuous sel=1 stream of 16 beats -> 16 beats appear on consecutive cycles with in_ready held at 1.
